frv_pipeline_pc_track: RTL and testbench

Decode-side stage directly downstream of the fetch stage. Consumes the fetch stage's s1 stream of whole 16- or 32-bit instructions and assigns each one its program counter. Buffers up to two instructions in a skid FIFO and presents {instr, pc, npc, size, error} to the decode/s2 stage. Resynchronises its PC on every control-flow flush.

---
 rtl/frv_pipeline_pc_track_pkg.sv | 34 +++
 rtl/frv_pipeline_pc_track_if.sv | 35 +++
 rtl/frv_pipeline_pc_track_fifo.sv | 65 ++++++
 rtl/frv_pipeline_pc_track.sv | 77 +++++++
 tb/tb_frv_pipeline_pc_track.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/frv_pipeline_pc_track_pkg.sv
// Shared definitions for the decode-side PC tracking stage: data width,
// reset PC, instruction-length encoding and the buffered entry layout.
package frv_pipeline_pc_track_pkg;

    localparam int XL = 32;

    // PC of the first instruction fetched after reset.
    localparam logic [XL-1:0] FRV_PC_RESET_VALUE_DEFAULT = 32'h8000_0000;

    // Low two bits of a 32-bit instruction; anything else is compressed.
    localparam logic [1:0] FRV_ILEN_32 = 2'b11;

    // One buffered instruction with its PC and fall-through PC (98 bits).
    typedef struct packed {
        logic [XL-1:0] instr;
        logic [XL-1:0] pc;
        logic [XL-1:0] npc;
        logic          size;   // 1 = 32-bit, 0 = 16-bit
        logic          error;
    } frv_pct_entry_t;

    // Error entries are always treated as 32-bit so the PC stays aligned
    // with what the fetch stage consumed.
    function automatic logic frv_is_32bit(input logic [1:0] low_bits,
                                          input logic       fetch_error);
        return (low_bits == FRV_ILEN_32) || fetch_error;
    endfunction

    // Byte length of an instruction of the given size.
    function automatic logic [XL-1:0] frv_instr_len(input logic size);
        return size ? 32'd4 : 32'd2;
    endfunction

endpackage

// File: rtl/frv_pipeline_pc_track_if.sv
// Fetch-side (s1) and decode-side (s2) handshake bundle of the PC tracker.
// The slave modport is the tracker's view, the master modport the
// surrounding pipeline's view.
interface frv_pipeline_pc_track_if;

    logic        s1_flush;
    logic [31:0] s1_flush_target;
    logic        s1_valid;
    logic [31:0] s1_data;
    logic        s1_error;
    logic        s1_busy;

    logic        s2_valid;
    logic [31:0] s2_instr;
    logic [31:0] s2_pc;
    logic [31:0] s2_npc;
    logic        s2_size;
    logic        s2_error;
    logic        s2_busy;

    modport slave (
        input  s1_flush, s1_flush_target, s1_valid, s1_data, s1_error,
        output s1_busy,
        output s2_valid, s2_instr, s2_pc, s2_npc, s2_size, s2_error,
        input  s2_busy
    );

    modport master (
        output s1_flush, s1_flush_target, s1_valid, s1_data, s1_error,
        input  s1_busy,
        input  s2_valid, s2_instr, s2_pc, s2_npc, s2_size, s2_error,
        output s2_busy
    );

endinterface

// File: rtl/frv_pipeline_pc_track_fifo.sv
// Two-entry synchronous skid FIFO of PC-tagged instructions. Flush empties
// it in one cycle; the head reads as all-zero while empty.
module frv_pipeline_pc_track_fifo
    import frv_pipeline_pc_track_pkg::*;
#(
    parameter int FRV_PCT_DEPTH = 2
) (
    input  logic           g_clk,
    input  logic           g_reset,
    input  logic           flush,
    input  logic           push,
    input  logic           pop,
    input  frv_pct_entry_t wr_entry,
    output frv_pct_entry_t rd_entry,
    output logic           valid,
    output logic           full
);

    frv_pct_entry_t mem [2];
    logic           rd_ptr;
    logic           wr_ptr;
    logic [1:0]     count;

    // Occupancy and pointer bookkeeping; reset beats flush beats push/pop.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else if (flush) begin
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage written at the write pointer.
    // NOTE: the storage array is not reset; count==0 already marks every
    // slot dead and the head output is masked to zero while empty.
    always_ff @(posedge g_clk) begin
        if (push) mem[wr_ptr] <= wr_entry;
    end

    // Head entry, forced to zero while the FIFO is empty.
    // NOTE: the output gets a default before the conditional so no latch
    // is inferred on the empty path.
    always_comb begin
        rd_entry = '0;
        if (valid) rd_entry = mem[rd_ptr];
    end

    assign valid = (count != 2'd0);
    assign full  = (count == 2'(FRV_PCT_DEPTH));

endmodule

// File: rtl/frv_pipeline_pc_track.sv
// Decode-side PC tracker: tags each whole instruction from fetch with its PC
// and fall-through PC, buffers up to two, and resynchronises on flush.
module frv_pipeline_pc_track
    import frv_pipeline_pc_track_pkg::*;
#(
    parameter logic [XL-1:0] FRV_PC_RESET_VALUE = FRV_PC_RESET_VALUE_DEFAULT,
    parameter int            FRV_PCT_DEPTH      = 2   // only 2 is supported
) (
    input logic                   g_clk,
    input logic                   g_reset,
    frv_pipeline_pc_track_if.slave pct
);

    logic [XL-1:0]  pc_next;
    logic           push;
    logic           pop;
    logic           fifo_valid;
    logic           fifo_full;
    logic           new_size;
    frv_pct_entry_t new_entry;
    frv_pct_entry_t head;

    // Flush suppresses both sides of the handshake for that cycle.
    assign push = pct.s1_valid && !pct.s1_busy  && !pct.s1_flush;
    assign pop  = pct.s2_valid && !pct.s2_busy  && !pct.s1_flush;

    // Build the entry for the instruction offered by fetch this cycle.
    always_comb begin
        new_size        = frv_is_32bit(pct.s1_data[1:0], pct.s1_error);
        new_entry       = '0;
        new_entry.size  = new_size;
        new_entry.error = pct.s1_error;
        new_entry.pc    = pc_next;
        new_entry.npc   = pc_next + frv_instr_len(new_size);
        if (pct.s1_error)
            new_entry.instr = '0;
        else if (new_size)
            new_entry.instr = pct.s1_data;
        else
            new_entry.instr = {16'b0, pct.s1_data[15:0]};
    end

    // PC of the next instruction to arrive; flush reloads it halfword-aligned.
    always_ff @(posedge g_clk) begin
        if (g_reset)
            pc_next <= FRV_PC_RESET_VALUE;
        else if (pct.s1_flush)
            pc_next <= pct.s1_flush_target & ~32'h1;
        else if (push)
            pc_next <= new_entry.npc;
    end

    frv_pipeline_pc_track_fifo #(
        .FRV_PCT_DEPTH (FRV_PCT_DEPTH)
    ) u_fifo (
        .g_clk    (g_clk),
        .g_reset  (g_reset),
        .flush    (pct.s1_flush),
        .push     (push),
        .pop      (pop),
        .wr_entry (new_entry),
        .rd_entry (head),
        .valid    (fifo_valid),
        .full     (fifo_full)
    );

    // Back-pressure depends only on stored occupancy, never on s2_busy.
    assign pct.s1_busy  = fifo_full;

    assign pct.s2_valid = fifo_valid;
    assign pct.s2_instr = head.instr;
    assign pct.s2_pc    = head.pc;
    assign pct.s2_npc   = head.npc;
    assign pct.s2_size  = head.size;
    assign pct.s2_error = head.error;

endmodule

// File: tb/tb_frv_pipeline_pc_track.sv
// Directed bench for the PC tracker: reset, mixed sizes, back-pressure,
// flush, PC wrap, error entries and reset during operation.
module tb_frv_pipeline_pc_track;

    logic g_clk;
    logic g_reset;
    int   n_checks;
    int   n_pass;

    frv_pipeline_pc_track_if bus();

    frv_pipeline_pc_track dut (
        .g_clk   (g_clk),
        .g_reset (g_reset),
        .pct     (bus)
    );

    initial g_clk = 1'b0;
    always #5 g_clk = ~g_clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // Advance one edge and settle, so outputs are sampled after the edge.
    task automatic step();
        @(posedge g_clk);
        #1;
    endtask

    task automatic check_head(input string tag, input logic [31:0] pc,
                              input logic [31:0] npc, input logic size,
                              input logic [31:0] instr);
        check({tag, ".valid"}, {31'b0, bus.s2_valid}, 32'd1);
        check({tag, ".pc"},    bus.s2_pc,  pc);
        check({tag, ".npc"},   bus.s2_npc, npc);
        check({tag, ".size"},  {31'b0, bus.s2_size}, {31'b0, size});
        check({tag, ".instr"}, bus.s2_instr, instr);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        g_reset  = 1'b1;
        bus.s1_flush        = 1'b0;
        bus.s1_flush_target = 32'h0;
        bus.s1_valid        = 1'b0;
        bus.s1_data         = 32'h0;
        bus.s1_error        = 1'b0;
        bus.s2_busy         = 1'b0;

        // 1. Reset
        step();
        step();
        g_reset = 1'b0;
        check("rst.s2_valid", {31'b0, bus.s2_valid}, 32'd0);
        check("rst.s1_busy",  {31'b0, bus.s1_busy},  32'd0);
        check("rst.s2_pc",    bus.s2_pc,    32'h0);
        check("rst.s2_instr", bus.s2_instr, 32'h0);

        // 2. Mixed sizes, second push coincides with pop at count=1
        bus.s1_valid = 1'b1;
        bus.s1_data  = 32'h0000_0013;
        step();
        check_head("mix0", 32'h8000_0000, 32'h8000_0004, 1'b1, 32'h0000_0013);
        bus.s1_data = 32'hABCD_4501;
        step();
        check_head("mix1", 32'h8000_0004, 32'h8000_0006, 1'b0, 32'h0000_4501);
        check("mix1.s1_busy", {31'b0, bus.s1_busy}, 32'd0);
        bus.s1_valid = 1'b0;
        step();
        check("mix.empty", {31'b0, bus.s2_valid}, 32'd0);

        // 3. Back-pressure: third instruction must wait, not be lost
        bus.s2_busy  = 1'b1;
        bus.s1_valid = 1'b1;
        bus.s1_data  = 32'h0000_0093;
        step();
        check("bp.busy1", {31'b0, bus.s1_busy}, 32'd0);
        bus.s1_data = 32'h0000_0001;
        step();
        check("bp.busy2", {31'b0, bus.s1_busy}, 32'd1);
        bus.s1_data = 32'h0000_0113;
        step();
        step();
        check("bp.busy_hold", {31'b0, bus.s1_busy}, 32'd1);
        check_head("bp.stall", 32'h8000_0006, 32'h8000_000A, 1'b1, 32'h0000_0093);
        bus.s2_busy = 1'b0;
        step();
        check_head("bp.pop_b", 32'h8000_000A, 32'h8000_000C, 1'b0, 32'h0000_0001);
        check("bp.busy_rel", {31'b0, bus.s1_busy}, 32'd0);
        step();
        check_head("bp.pop_c", 32'h8000_000C, 32'h8000_0010, 1'b1, 32'h0000_0113);
        bus.s1_valid = 1'b0;
        step();
        check("bp.empty", {31'b0, bus.s2_valid}, 32'd0);

        // 4. Flush while full with s1_valid held high
        bus.s2_busy  = 1'b1;
        bus.s1_valid = 1'b1;
        bus.s1_data  = 32'h0000_0013;
        step();
        step();
        check("fl.full", {31'b0, bus.s1_busy}, 32'd1);
        bus.s1_flush        = 1'b1;
        bus.s1_flush_target = 32'h8000_1003;
        step();
        check("fl.s2_valid", {31'b0, bus.s2_valid}, 32'd0);
        check("fl.s1_busy",  {31'b0, bus.s1_busy},  32'd0);
        bus.s1_flush = 1'b0;
        bus.s2_busy  = 1'b0;
        bus.s1_data  = 32'h0000_4501;
        step();
        check_head("fl.push", 32'h8000_1002, 32'h8000_1004, 1'b0, 32'h0000_4501);
        bus.s1_valid = 1'b0;
        step();
        check("fl.empty", {31'b0, bus.s2_valid}, 32'd0);

        // 5. PC wrap-around
        bus.s1_flush        = 1'b1;
        bus.s1_flush_target = 32'hFFFF_FFFE;
        step();
        bus.s1_flush = 1'b0;
        bus.s2_busy  = 1'b1;
        bus.s1_valid = 1'b1;
        bus.s1_data  = 32'h0000_0001;
        step();
        check_head("wrap0", 32'hFFFF_FFFE, 32'h0000_0000, 1'b0, 32'h0000_0001);
        bus.s1_data = 32'h0000_0013;
        step();
        bus.s1_valid = 1'b0;
        bus.s2_busy  = 1'b0;
        step();
        check_head("wrap1", 32'h0000_0000, 32'h0000_0004, 1'b1, 32'h0000_0013);
        step();
        check("wrap.empty", {31'b0, bus.s2_valid}, 32'd0);

        // 6. Error entry: forced 32-bit, instr zeroed
        bus.s1_valid = 1'b1;
        bus.s1_error = 1'b1;
        bus.s1_data  = 32'h0000_0001;
        step();
        check_head("err", 32'h0000_0004, 32'h0000_0008, 1'b1, 32'h0000_0000);
        check("err.flag", {31'b0, bus.s2_error}, 32'd1);
        bus.s1_valid = 1'b0;
        bus.s1_error = 1'b0;
        step();
        check("err.empty_valid", {31'b0, bus.s2_valid}, 32'd0);
        check("err.empty_error", {31'b0, bus.s2_error}, 32'd0);

        // 7. Reset mid-operation, together with a flush: reset wins
        bus.s2_busy  = 1'b1;
        bus.s1_valid = 1'b1;
        bus.s1_data  = 32'h0000_0013;
        step();
        step();
        g_reset             = 1'b1;
        bus.s1_flush        = 1'b1;
        bus.s1_flush_target = 32'h1234_5678;
        step();
        check("mrst.s2_valid", {31'b0, bus.s2_valid}, 32'd0);
        check("mrst.s1_busy",  {31'b0, bus.s1_busy},  32'd0);
        g_reset      = 1'b0;
        bus.s1_flush = 1'b0;
        bus.s2_busy  = 1'b0;
        bus.s1_data  = 32'h0000_0001;
        step();
        check_head("mrst.push", 32'h8000_0000, 32'h8000_0002, 1'b0, 32'h0000_0001);
        bus.s1_valid = 1'b0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
